// File: rtl/rf_pkg.sv
// Shared widths, constants and the quarter-wave sine table for the RF modulator.
package rf_pkg;

  localparam int unsigned PHASE_W    = 32;
  localparam int unsigned LUT_AW     = 8;
  localparam int unsigned SIN_W      = 8;
  localparam int unsigned VID_W      = 6;
  localparam int unsigned AMP_W      = 6;
  localparam int unsigned RF_W       = 7;
  localparam int unsigned PROD_W     = 15;
  localparam int unsigned PROD_SHIFT = 7;
  localparam int unsigned QTR_AW     = 6;
  localparam int unsigned QTR_W      = 7;

  localparam logic [RF_W-1:0] RF_MID = 7'd64;

  // round(127*sin(2*pi*k/256)) for k = 0..63; k = 64 (127) is handled by the mirror logic
  function automatic logic [QTR_W-1:0] quarter_sin(input logic [QTR_AW-1:0] k);
    quarter_sin = '0;
    case (k)
      6'd0:  quarter_sin = 7'd0;   6'd1:  quarter_sin = 7'd3;   6'd2:  quarter_sin = 7'd6;   6'd3:  quarter_sin = 7'd9;
      6'd4:  quarter_sin = 7'd12;  6'd5:  quarter_sin = 7'd16;  6'd6:  quarter_sin = 7'd19;  6'd7:  quarter_sin = 7'd22;
      6'd8:  quarter_sin = 7'd25;  6'd9:  quarter_sin = 7'd28;  6'd10: quarter_sin = 7'd31;  6'd11: quarter_sin = 7'd34;
      6'd12: quarter_sin = 7'd37;  6'd13: quarter_sin = 7'd40;  6'd14: quarter_sin = 7'd43;  6'd15: quarter_sin = 7'd46;
      6'd16: quarter_sin = 7'd49;  6'd17: quarter_sin = 7'd51;  6'd18: quarter_sin = 7'd54;  6'd19: quarter_sin = 7'd57;
      6'd20: quarter_sin = 7'd60;  6'd21: quarter_sin = 7'd63;  6'd22: quarter_sin = 7'd65;  6'd23: quarter_sin = 7'd68;
      6'd24: quarter_sin = 7'd71;  6'd25: quarter_sin = 7'd73;  6'd26: quarter_sin = 7'd76;  6'd27: quarter_sin = 7'd78;
      6'd28: quarter_sin = 7'd81;  6'd29: quarter_sin = 7'd83;  6'd30: quarter_sin = 7'd85;  6'd31: quarter_sin = 7'd88;
      6'd32: quarter_sin = 7'd90;  6'd33: quarter_sin = 7'd92;  6'd34: quarter_sin = 7'd94;  6'd35: quarter_sin = 7'd96;
      6'd36: quarter_sin = 7'd98;  6'd37: quarter_sin = 7'd100; 6'd38: quarter_sin = 7'd102; 6'd39: quarter_sin = 7'd104;
      6'd40: quarter_sin = 7'd106; 6'd41: quarter_sin = 7'd107; 6'd42: quarter_sin = 7'd109; 6'd43: quarter_sin = 7'd111;
      6'd44: quarter_sin = 7'd112; 6'd45: quarter_sin = 7'd113; 6'd46: quarter_sin = 7'd115; 6'd47: quarter_sin = 7'd116;
      6'd48: quarter_sin = 7'd117; 6'd49: quarter_sin = 7'd118; 6'd50: quarter_sin = 7'd120; 6'd51: quarter_sin = 7'd121;
      6'd52: quarter_sin = 7'd122; 6'd53: quarter_sin = 7'd122; 6'd54: quarter_sin = 7'd123; 6'd55: quarter_sin = 7'd124;
      6'd56: quarter_sin = 7'd125; 6'd57: quarter_sin = 7'd125; 6'd58: quarter_sin = 7'd126; 6'd59: quarter_sin = 7'd126;
      6'd60: quarter_sin = 7'd126; 6'd61: quarter_sin = 7'd127; 6'd62: quarter_sin = 7'd127; 6'd63: quarter_sin = 7'd127;
      default: quarter_sin = '0;
    endcase
  endfunction

endpackage

// File: rtl/rf_waever_if.sv
// Video-in / RF-sample-out bus between the modulator and its source/sink.
interface rf_waever_if;
  import rf_pkg::*;

  logic [VID_W-1:0] video;
  logic [RF_W-1:0]  rf;

  modport master (output video, input rf);
  modport slave  (input video, output rf);
endinterface

// File: rtl/rf_sine_lut.sv
// Full-period signed sine from a 64-entry quarter-wave ROM; registered, 1-cycle latency.
module rf_sine_lut
  import rf_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [LUT_AW-1:0]        idx_i,
  output logic signed [SIN_W-1:0]  sin_o
);

  logic [1:0]              quad_c;
  logic [QTR_AW-1:0]       low_c;
  logic [SIN_W-1:0]        mag_c;
  logic signed [SIN_W-1:0] sin_d, sin_q;

  assign quad_c = idx_i[LUT_AW-1 -: 2];
  assign low_c  = idx_i[QTR_AW-1:0];

  // Odd quadrants read the table backwards; their first entry is the peak, outside the table
  always_comb begin
    mag_c = '0;
    sin_d = '0;
    if (!quad_c[0]) begin
      mag_c = SIN_W'(quarter_sin(low_c));
    end else if (low_c == '0) begin
      mag_c = SIN_W'(127);
    end else begin
      mag_c = SIN_W'(quarter_sin(QTR_AW'(7'd64 - {1'b0, low_c})));
    end
    sin_d = quad_c[1] ? SIN_W'(8'd0 - mag_c) : mag_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sin_q <= '0;
    else        sin_q <= sin_d;
  end

  assign sin_o = sin_q;

endmodule

// File: rtl/rf_waever.sv
// Negative-AM RF modulator: NCO + sine LUT carrier, envelope from composite video level.
module rf_waever
  import rf_pkg::*;
#(
  parameter logic [PHASE_W-1:0] PHASE_INC = 32'd1423781659,
  parameter int unsigned        RESIDUAL  = 6,
  parameter int unsigned        LPF_SHIFT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  rf_waever_if.slave  bus
);

  logic [PHASE_W-1:0]       phase_q, phase_d;
  logic [VID_W-1:0]         vid_c;
  logic [AMP_W-1:0]         env_c;
  logic [AMP_W-1:0]         amp_q, amp_d;
  logic signed [SIN_W-1:0]  sin_c;
  logic signed [PROD_W-1:0] prod_c;
  logic signed [SIN_W-1:0]  shf_c;
  logic [RF_W-1:0]          rf_q, rf_d;

  // Stage 1 video path: either a plain register or a first-order IIR smoother
  if (LPF_SHIFT == 0) begin : g_bypass
    logic [VID_W-1:0] vid_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vid_q <= '0;
      else        vid_q <= bus.video;
    end
    assign vid_c = vid_q;
  end else begin : g_iir
    localparam int unsigned VF_W = VID_W + LPF_SHIFT;
    logic [VF_W-1:0]   vf_q, vf_d;
    logic signed [VF_W:0] diff_c;
    always_comb begin
      diff_c = $signed({1'b0, bus.video, {LPF_SHIFT{1'b0}}}) - $signed({1'b0, vf_q});
      vf_d   = vf_q + VF_W'(diff_c >>> LPF_SHIFT);
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vf_q <= '0;
      else        vf_q <= vf_d;
    end
    assign vid_c = vf_q[VF_W-1 -: VID_W];
  end

  rf_sine_lut u_lut (
    .clk   (clk),
    .rst_n (rst_n),
    .idx_i (phase_q[PHASE_W-1 -: LUT_AW]),
    .sin_o (sin_c)
  );

  // Negative AM: sync tip gives full carrier, white is floored at the residual level
  always_comb begin
    phase_d = phase_q + PHASE_INC;
    env_c   = AMP_W'(63) - vid_c;
    amp_d   = (env_c < AMP_W'(RESIDUAL)) ? AMP_W'(RESIDUAL) : env_c;
    prod_c  = PROD_W'(sin_c) * PROD_W'($signed({1'b0, amp_q}));
    shf_c   = SIN_W'(prod_c >>> PROD_SHIFT);
    rf_d    = RF_MID + RF_W'(shf_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
      amp_q   <= '0;
      rf_q    <= RF_MID;
    end else begin
      phase_q <= phase_d;
      amp_q   <= amp_d;
      rf_q    <= rf_d;
    end
  end

  assign bus.rf = rf_q;

endmodule

// File: tb/tb_rf_waever.sv
// Bench for rf_waever: a quarter-rate carrier instance and a default-rate instance.
module tb_rf_waever;

  localparam logic [31:0] INC_Q = 32'h4000_0000;
  localparam logic [31:0] INC_D = 32'd1423781659;
  localparam int          RES   = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  rf_waever_if bus_q ();
  rf_waever_if bus_d ();

  rf_waever #(.PHASE_INC(INC_Q), .RESIDUAL(RES), .LPF_SHIFT(0)) dut_q (
    .clk (clk), .rst_n (rst_n), .bus (bus_q)
  );
  rf_waever #(.PHASE_INC(INC_D), .RESIDUAL(RES), .LPF_SHIFT(0)) dut_d (
    .clk (clk), .rst_n (rst_n), .bus (bus_d)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int k     = 0;
  int hq[$];
  int hd[$];

  logic [6:0] pat0  [4] = '{7'd64, 7'd126, 7'd64, 7'd1};
  logic [6:0] pat63 [4] = '{7'd64, 7'd69,  7'd64, 7'd58};

  function automatic int ref_sin(int idx);
    real r;
    r = 127.0 * $sin(2.0 * 3.14159265358979 * real'(idx) / 256.0);
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
  endfunction

  // Sample after edge kk: carrier phase (kk-2)*inc, envelope from the video captured at edge kk-2
  function automatic int ref_rf(longint unsigned inc, int kk, int vid);
    longint unsigned ph;
    int amp;
    if (kk < 2) return 64;
    ph  = (longint'(kk - 2) * inc) & 64'hFFFF_FFFF;
    amp = 63 - vid;
    if (amp < RES) amp = RES;
    return 64 + $rtoi($floor(real'(ref_sin(int'(ph >> 24)) * amp) / 128.0));
  endfunction

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d (edge %0d)", tag, obs, exp, k);
    end
  endtask

  task automatic model_reset();
    hq.delete(); hd.delete();
    hq.push_back(0); hd.push_back(0);
    k = 0;
  endtask

  task automatic cycle(input logic [5:0] vq, input logic [5:0] vd);
    int oq, od;
    bus_q.video = vq;
    bus_d.video = vd;
    hq.push_back(int'(vq));
    hd.push_back(int'(vd));
    @(posedge clk);
    #1;
    k++;
    oq = (k >= 2) ? hq[k-2] : 0;
    od = (k >= 2) ? hd[k-2] : 0;
    chk("model_q", bus_q.rf, 7'(ref_rf(INC_Q, k, oq)));
    chk("model_d", bus_d.rf, 7'(ref_rf(INC_D, k, od)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int dev, dev_lo, dev_hi;
    logic [5:0] sq;

    bus_q.video = '0;
    bus_d.video = '0;

    // Held in reset while the clock runs
    repeat (4) begin
      @(posedge clk); #1;
      chk("rst_hold_q", bus_q.rf, 7'd64);
      chk("rst_hold_d", bus_d.rf, 7'd64);
    end

    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Full carrier at sync level: 64,126,64,1 from the second edge on
    repeat (14) begin
      cycle(6'd0, 6'($urandom_range(0, 63)));
      if (k < 2) chk("post_rst_q", bus_q.rf, 7'd64);
      else       chk("pat_sync", bus_q.rf, pat0[(k-2)%4]);
    end

    // Step to white right after edge n; envelope must switch at edge n+3
    n = k;
    repeat (14) begin
      cycle(6'd63, 6'($urandom_range(0, 63)));
      if (k <= n + 2) chk("step_early", bus_q.rf, pat0[(k-2)%4]);
      else            chk("pat_white", bus_q.rf, pat63[(k-2)%4]);
    end

    repeat (7) cycle(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));

    // Asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_q", bus_q.rf, 7'd64);
    chk("async_rst_d", bus_d.rf, 7'd64);
    @(negedge clk);
    chk("rst_again_q", bus_q.rf, 7'd64);
    rst_n = 1'b1;
    model_reset();
    repeat (10) begin
      cycle(6'd0, 6'd0);
      if (k < 2) chk("restart_q", bus_q.rf, 7'd64);
      else       chk("restart_pat", bus_q.rf, pat0[(k-2)%4]);
    end

    // Random video on both instances
    repeat (3000) cycle(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));

    // Square video on the default-rate instance: range and inverse envelope
    dev_lo = 0;
    dev_hi = 0;
    for (int i = 0; i < 8000; i++) begin
      sq = ((i / 1000) % 2 == 0) ? 6'd0 : 6'd63;
      cycle(6'($urandom_range(0, 63)), sq);
      chk("range_d", 7'(bus_d.rf >= 7'd1 && bus_d.rf <= 7'd126), 7'd1);
      if (i % 1000 >= 3) begin
        dev = int'(bus_d.rf) - 64;
        if (dev < 0) dev = -dev;
        if (hd[k-2] == 0) begin
          if (dev > dev_lo) dev_lo = dev;
        end else begin
          if (dev > dev_hi) dev_hi = dev;
        end
      end
    end
    chk("env_sync_deep", 7'(dev_lo >= 60), 7'd1);
    chk("env_white_low", 7'(dev_hi <= RES), 7'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
